// File: rtl/accel_pkg.sv
// Shared constants for the layer activation pipeline: stage FSM encoding and activation selects.
package accel_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACT  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam logic [1:0] ACT_IDENT = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_LEAKY = 2'd2;

  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/act_unit.sv
// Combinational activation of one signed word (identity / ReLU / leaky >>>3); zero latency, no flow control.
module act_unit
  import accel_pkg::*;
#(
  parameter int bitw = 16
) (
  input  logic [bitw-1:0] in,
  input  logic [1:0]      mode,
  output logic [bitw-1:0] out
);

  // Kept in its own signed net so the arithmetic shift is not demoted to logical by context
  logic signed [bitw-1:0] leak;
  logic                   neg;

  assign leak = $signed(in) >>> LEAKY_SHIFT;
  assign neg  = in[bitw-1];

  always_comb begin
    out = in;
    case (mode)
      ACT_RELU:  out = neg ? '0 : in;
      ACT_LEAKY: out = neg ? leak : in;
      default:   out = in;
    endcase
  end

endmodule

// File: rtl/layer_act_stage.sv
// Captures a layer vector on the in_ready rising edge and activates one element per cycle; x_ready after dim cycles.
// Holds x until out_ack; an upstream vector arriving while busy (except on the acking edge) is dropped and flagged.
module layer_act_stage
  import accel_pkg::*;
#(
  parameter int dim      = 4,
  parameter int bitw     = 16,
  parameter int fracw    = 8,
  parameter int act_mode = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_ready,
  input  logic [dim-1:0][bitw-1:0]  in_vec,
  input  logic                      out_ack,
  output logic                      x_ready,
  output logic [dim-1:0][bitw-1:0]  x,
  output logic                      busy,
  output logic                      overrun
);

  localparam int          IW   = (dim > 1) ? $clog2(dim) : 1;
  localparam logic [IW-1:0] LAST = IW'(dim - 1);

  if (fracw >= bitw) begin : g_bad_fracw
    $error("fracw must be smaller than bitw");
  end
  if (act_mode > 2) begin : g_bad_mode
    $error("act_mode must be 0, 1 or 2");
  end

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     in_ready_q, in_ready_d;
  logic                     armed_q, armed_d;
  logic [dim-1:0][bitw-1:0] raw_q, raw_d;
  logic [dim-1:0][bitw-1:0] x_q, x_d;
  logic                     x_ready_q, x_ready_d;
  logic                     overrun_q, overrun_d;
  logic                     start;
  logic [bitw-1:0]          act_in;
  logic [bitw-1:0]          act_out;

  // armed_q blocks a start until in_ready has been seen low once after reset
  assign start  = in_ready & ~in_ready_q & armed_q;
  assign act_in = raw_q[idx_q];

  act_unit #(.bitw(bitw)) u_act (
    .in   (act_in),
    .mode (2'(act_mode)),
    .out  (act_out)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    in_ready_d = in_ready;
    armed_d    = armed_q | ~in_ready;
    raw_d      = raw_q;
    x_d        = x_q;
    x_ready_d  = x_ready_q;
    overrun_d  = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          raw_d   = in_vec;
          idx_d   = '0;
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        x_d[idx_q] = act_out;
        if (idx_q == LAST) begin
          idx_d     = '0;
          state_d   = ST_HOLD;
          x_ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (start) overrun_d = 1'b1;
      end
      ST_HOLD: begin
        if (out_ack) begin
          x_ready_d = 1'b0;
          state_d   = ST_IDLE;
          if (start) begin
            raw_d   = in_vec;
            idx_d   = '0;
            state_d = ST_ACT;
          end
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        idx_d     = '0;
        x_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      armed_q    <= 1'b0;
      raw_q      <= '0;
      x_q        <= '0;
      x_ready_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      armed_q    <= armed_d;
      raw_q      <= raw_d;
      x_q        <= x_d;
      x_ready_q  <= x_ready_d;
      overrun_q  <= overrun_d;
    end
  end

  assign x_ready = x_ready_q;
  assign x       = x_q;
  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: doc/layer_act_stage.md
LAYER_ACT_STAGE -- requirements
Module: layer_act_stage

Interface
REQ-001 SHALL have parameter dim, default 4, elements per layer vector.
REQ-002 SHALL have parameter bitw, default 16, signed fixed-point word width.
REQ-003 SHALL have parameter fracw, default 8, fractional bits (carried only, no rescaling).
REQ-004 SHALL have parameter act_mode, default 1, activation select: 0 identity, 1 ReLU, 2 leaky (negatives arithmetic-shifted right by 3).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_ready  input  1  layer-complete level from the upstream core row.
REQ-008 SHALL have port in_vec  input  dim x bitw  upstream layer vector, valid while in_ready high.
REQ-009 SHALL have port out_ack  input  1  downstream consumed x.
REQ-010 SHALL have port x_ready  output  1  activated vector valid for the next core row.
REQ-011 SHALL have port x  output  dim x bitw  activated vector.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port overrun  output  1  sticky flag: an upstream vector was dropped.

Function
REQ-014 SHALL register in_ready into in_ready_q every cycle; "start" is in_ready=1 and in_ready_q=0.
REQ-015 SHALL implement states IDLE, ACT, HOLD.
REQ-016 IDLE: on start, SHALL copy in_vec into the internal raw buffer at that edge, clear index to 0, and go to ACT.
REQ-017 ACT: each cycle SHALL write act(raw[index]) into x[index] and increment index; at index=dim-1 it SHALL go to HOLD and set x_ready at the same edge.
REQ-018 x_ready SHALL therefore be first visible exactly dim cycles after the capture edge.
REQ-019 HOLD: x and x_ready SHALL be stable; on out_ack=1, x_ready SHALL clear at that edge and the state SHALL go to IDLE.
REQ-020 HOLD with out_ack=1 and start in the same cycle SHALL capture the new vector and go directly to ACT, with no loss and no overrun.
REQ-021 A start in ACT, or in HOLD without out_ack, SHALL set overrun and discard the vector; the current operation SHALL be unaffected.
REQ-022 out_ack outside HOLD SHALL be ignored.
REQ-023 x SHALL retain its last values after leaving HOLD until overwritten element-by-element in the next ACT.
REQ-024 ReLU SHALL output 0 for a negative input (MSB=1) and pass all other values unchanged.
REQ-025 Leaky SHALL output value>>>3 (sign-extending) for negative inputs and pass non-negative inputs unchanged; no rounding.
REQ-026 Output width SHALL equal bitw; no saturation is needed because no transform grows magnitude.
REQ-027 overrun SHALL clear only on reset.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, index 0, in_ready_q 0, x_ready 0, busy 0, overrun 0, x all 0, raw buffer all 0.
REQ-029 Reset mid-ACT or mid-HOLD SHALL abandon the vector; after release, a new start SHALL require in_ready to be seen low for at least one cycle.

Structure
REQ-030 The state enum (IDLE, ACT, HOLD) and activation-mode constants SHALL live in the shared package accel_pkg.
REQ-031 Activation SHALL be a single combinational sub-module act_unit (ports: in, mode, out; bitw-parameterised), instantiated once and time-multiplexed by index.

Verification
REQ-032 ReLU, dim=4: in_vec=[0x0100,0xFF00,0x3C44,0xC9BD], pulse in_ready -> after 4 cycles x_ready=1, x=[0x0100,0x0000,0x3C44,0x0000].
REQ-033 Leaky, same input -> x=[0x0100,0xFFE0,0x3C44,0xF937].
REQ-034 Second in_ready rising edge 2 cycles after the first -> overrun=1; x still equals the result of the first vector.
REQ-035 In HOLD, out_ack and a new start on the same edge -> x_ready low for exactly dim cycles, then high with the new vector, and overrun=0.
REQ-036 reset_n low while in ACT at index 2 -> x_ready, busy and all x are immediately 0; in_ready still high after release -> no capture until it falls and rises again.
REQ-037 in_ready held high for 10 cycles -> exactly one capture, and out_ack in IDLE has no effect.
